ex_mem_pipe_reg: RTL and testbench

//  Parametrised EX->MEM pipeline register for the MIPS CPU with interrupt support.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/mem_lane_ctrl.sv | 79 +++++++
 rtl/ex_mem_pipe_reg.sv | 115 +++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the EX->MEM boundary: memory-op codes, CP0 exception codes,
// load-size codes and the interrupt handler entry point.
package cpu_pkg;

    localparam int unsigned MEM_OP_W   = 4;
    localparam int unsigned LD_SIZE_W  = 2;
    localparam int unsigned BYTEEN_W   = 4;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NONE = 4'd0,
        MEM_LW   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LHU  = 4'd3,
        MEM_LB   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_SW   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SB   = 4'd8
    } mem_op_e;

    localparam int unsigned EXC_ADEL = 4;
    localparam int unsigned EXC_ADES = 5;
    localparam int unsigned EXC_OV   = 12;

    localparam logic [LD_SIZE_W-1:0] LD_NONE = 2'd0;
    localparam logic [LD_SIZE_W-1:0] LD_BYTE = 2'd1;
    localparam logic [LD_SIZE_W-1:0] LD_HALF = 2'd2;
    localparam logic [LD_SIZE_W-1:0] LD_WORD = 2'd3;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return op inside {MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU};
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return op inside {MEM_SW, MEM_SH, MEM_SB};
    endfunction

endpackage

// File: rtl/mem_lane_ctrl.sv
// Combinational MEM-stage pre-decode: byte enables, lane-replicated store data,
// load size/sign and first-exception-wins code merging.
module mem_lane_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned EXC_W  = 5
) (
    input  logic [MEM_OP_W-1:0]  mem_op,
    input  logic [1:0]           ao_lo,
    input  logic [DATA_W-1:0]    rd2,
    input  logic                 ov,
    input  logic                 valid,
    input  logic [EXC_W-1:0]     exc_in,
    output logic [BYTEEN_W-1:0]  byteen_c,
    output logic [DATA_W-1:0]    wdata_c,
    output logic [LD_SIZE_W-1:0] ld_size_c,
    output logic                 ld_sext_c,
    output logic [EXC_W-1:0]     exc_c
);

    logic                 load_misal;
    logic                 store_misal;
    logic [BYTEEN_W-1:0]  be_raw;
    logic [LD_SIZE_W-1:0] size_raw;
    logic                 sext_raw;
    logic                 op_ld;
    logic                 op_st;
    logic                 ok;

    // Per-op lane decode before exception gating
    always_comb begin
        load_misal  = 1'b0;
        store_misal = 1'b0;
        be_raw      = '0;
        size_raw    = LD_NONE;
        sext_raw    = 1'b0;
        wdata_c     = rd2;
        case (mem_op)
            MEM_LW:  begin size_raw = LD_WORD; load_misal = (ao_lo != 2'b00); end
            MEM_LH:  begin size_raw = LD_HALF; sext_raw = 1'b1; load_misal = ao_lo[0]; end
            MEM_LHU: begin size_raw = LD_HALF; load_misal = ao_lo[0]; end
            MEM_LB:  begin size_raw = LD_BYTE; sext_raw = 1'b1; end
            MEM_LBU: begin size_raw = LD_BYTE; end
            MEM_SW:  begin be_raw = 4'b1111; store_misal = (ao_lo != 2'b00); end
            MEM_SH:  begin
                be_raw      = 4'b0011 << {ao_lo[1], 1'b0};
                wdata_c     = {2{rd2[15:0]}};
                store_misal = ao_lo[0];
            end
            MEM_SB:  begin
                be_raw  = 4'b0001 << ao_lo;
                wdata_c = {4{rd2[7:0]}};
            end
            default: ;
        endcase
    end

    // Earlier-stage exception beats address faults, which beat plain overflow
    always_comb begin
        op_ld = is_load(mem_op);
        op_st = is_store(mem_op);
        if (exc_in != '0)
            exc_c = exc_in;
        else if (op_ld && (load_misal || ov))
            exc_c = EXC_W'(EXC_ADEL);
        else if (op_st && (store_misal || ov))
            exc_c = EXC_W'(EXC_ADES);
        else if (ov && !op_ld && !op_st)
            exc_c = EXC_W'(EXC_OV);
        else
            exc_c = '0;
        ok        = valid && (exc_c == '0);
        byteen_c  = ok ? be_raw : '0;
        ld_size_c = ok ? size_raw : LD_NONE;
        ld_sext_c = ok && sext_raw;
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall/flush/interrupt-redirect priority and
// registered MEM-stage controls pre-decoded from the EX bundle.
module ex_mem_pipe_reg
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned EXC_W      = 5,
    parameter int unsigned SIDE_W     = 8,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 int_req,
    input  logic                 e_valid,
    input  logic [31:0]          e_instr,
    input  logic [31:0]          e_pc,
    input  logic [DATA_W-1:0]    e_ao,
    input  logic [DATA_W-1:0]    e_rd2,
    input  logic [MEM_OP_W-1:0]  e_mem_op,
    input  logic                 e_mtc0,
    input  logic                 e_ov,
    input  logic                 e_bd,
    input  logic [EXC_W-1:0]     e_exc,
    input  logic [SIDE_W-1:0]    e_side,
    output logic                 m_valid,
    output logic [31:0]          m_instr,
    output logic [31:0]          m_pc,
    output logic [DATA_W-1:0]    m_ao,
    output logic [DATA_W-1:0]    m_rd2,
    output logic                 m_bd,
    output logic [EXC_W-1:0]     m_exc,
    output logic [BYTEEN_W-1:0]  m_byteen,
    output logic [DATA_W-1:0]    m_wdata,
    output logic [LD_SIZE_W-1:0] m_ld_size,
    output logic                 m_ld_sext,
    output logic                 m_cp0_we,
    output logic [SIDE_W-1:0]    m_side
);

    logic [BYTEEN_W-1:0]  byteen_c;
    logic [DATA_W-1:0]    wdata_c;
    logic [LD_SIZE_W-1:0] ld_size_c;
    logic                 ld_sext_c;
    logic [EXC_W-1:0]     exc_c;
    logic                 cp0_we_c;

    mem_lane_ctrl #(
        .DATA_W (DATA_W),
        .EXC_W  (EXC_W)
    ) u_lane (
        .mem_op    (e_mem_op),
        .ao_lo     (e_ao[1:0]),
        .rd2       (e_rd2),
        .ov        (e_ov),
        .valid     (e_valid),
        .exc_in    (e_exc),
        .byteen_c  (byteen_c),
        .wdata_c   (wdata_c),
        .ld_size_c (ld_size_c),
        .ld_sext_c (ld_sext_c),
        .exc_c     (exc_c)
    );

    assign cp0_we_c = e_mtc0 && e_valid && (exc_c == '0);

    // Priority: int_req > flush > stall > load; bubbles differ only in PC/BD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid   <= 1'b0;
            m_instr   <= '0;
            m_pc      <= '0;
            m_ao      <= '0;
            m_rd2     <= '0;
            m_bd      <= 1'b0;
            m_exc     <= '0;
            m_byteen  <= '0;
            m_wdata   <= '0;
            m_ld_size <= LD_NONE;
            m_ld_sext <= 1'b0;
            m_cp0_we  <= 1'b0;
            m_side    <= '0;
        end else if (int_req || flush) begin
            m_valid   <= 1'b0;
            m_instr   <= '0;
            m_pc      <= int_req ? HANDLER_PC : e_pc;
            m_ao      <= '0;
            m_rd2     <= '0;
            m_bd      <= int_req ? 1'b0 : e_bd;
            m_exc     <= '0;
            m_byteen  <= '0;
            m_wdata   <= '0;
            m_ld_size <= LD_NONE;
            m_ld_sext <= 1'b0;
            m_cp0_we  <= 1'b0;
            m_side    <= '0;
        end else if (!stall) begin
            m_valid   <= e_valid;
            m_instr   <= e_instr;
            m_pc      <= e_pc;
            m_ao      <= e_ao;
            m_rd2     <= e_rd2;
            m_bd      <= e_bd;
            m_exc     <= exc_c;
            m_byteen  <= byteen_c;
            m_wdata   <= wdata_c;
            m_ld_size <= ld_size_c;
            m_ld_sext <= ld_sext_c;
            m_cp0_we  <= cp0_we_c;
            m_side    <= e_side;
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench for ex_mem_pipe_reg: reset, lane decode, exception
// merge, stall hold, interrupt redirect and flush bubble.
module tb_ex_mem_pipe_reg;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, int_req;
    logic        e_valid, e_mtc0, e_ov, e_bd;
    logic [31:0] e_instr, e_pc, e_ao, e_rd2;
    logic [3:0]  e_mem_op;
    logic [4:0]  e_exc;
    logic [7:0]  e_side;
    logic        m_valid, m_bd, m_ld_sext, m_cp0_we;
    logic [31:0] m_instr, m_pc, m_ao, m_rd2, m_wdata;
    logic [4:0]  m_exc;
    logic [3:0]  m_byteen;
    logic [1:0]  m_ld_size;
    logic [7:0]  m_side;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_req(int_req),
        .e_valid(e_valid), .e_instr(e_instr), .e_pc(e_pc), .e_ao(e_ao), .e_rd2(e_rd2),
        .e_mem_op(e_mem_op), .e_mtc0(e_mtc0), .e_ov(e_ov), .e_bd(e_bd), .e_exc(e_exc),
        .e_side(e_side),
        .m_valid(m_valid), .m_instr(m_instr), .m_pc(m_pc), .m_ao(m_ao), .m_rd2(m_rd2),
        .m_bd(m_bd), .m_exc(m_exc), .m_byteen(m_byteen), .m_wdata(m_wdata),
        .m_ld_size(m_ld_size), .m_ld_sext(m_ld_sext), .m_cp0_we(m_cp0_we), .m_side(m_side)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; int_req = 0;
        e_valid = 0; e_mtc0 = 0; e_ov = 0; e_bd = 0;
        e_instr = '0; e_pc = '0; e_ao = '0; e_rd2 = '0;
        e_mem_op = MEM_NONE; e_exc = '0; e_side = '0;
    endtask

    task automatic set_ex(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] ao,
                          input logic [31:0] rd2, input logic ov, input logic [4:0] exc);
        e_valid = 1; e_mem_op = op; e_pc = pc; e_ao = ao; e_rd2 = rd2; e_ov = ov; e_exc = exc;
        e_instr = {8'hA5, pc[23:0]}; e_side = pc[7:0] ^ 8'h3C;
    endtask

    task automatic set_all_nonzero();
        stall = 1; flush = 1; int_req = 1;
        e_valid = 1; e_mtc0 = 1; e_ov = 1; e_bd = 1;
        e_instr = 32'hFFFF_FFFF; e_pc = 32'h1234_5678; e_ao = 32'h0000_1003;
        e_rd2 = 32'hDEAD_BEEF; e_mem_op = MEM_SW; e_exc = 5'd10; e_side = 8'hFF;
    endtask

    task automatic test_reset();
        reset = 0;
        set_all_nonzero();
        #2;
        tests++; if (m_valid !== 1'b0 || m_pc !== 32'h0 || m_instr !== 32'h0) begin fails++; $display("FAIL reset_initial: valid=%b pc=%h instr=%h, want 0/0/0", m_valid, m_pc, m_instr); end
        step();
        clear_inputs();
        reset = 1;
        set_ex(MEM_LW, 32'h0000_0100, 32'h0000_2000, 32'h0, 0, 0);
        e_side = 8'h5A;
        step();
        tests++; if (m_valid !== 1'b1 || m_pc !== 32'h0000_0100) begin fails++; $display("FAIL load_basic: valid=%b pc=%h, want 1/00000100", m_valid, m_pc); end
        tests++; if (m_ld_size !== 2'd3 || m_ld_sext !== 1'b0 || m_side !== 8'h5A) begin fails++; $display("FAIL load_basic_ctl: size=%0d sext=%b side=%h, want 3/0/5a", m_ld_size, m_ld_sext, m_side); end
        set_all_nonzero();
        #1 reset = 0;
        #1;
        tests++; if ({m_valid, m_pc, m_instr, m_ao, m_rd2, m_bd, m_exc, m_byteen, m_wdata, m_ld_size, m_ld_sext, m_cp0_we, m_side} !== '0) begin fails++; $display("FAIL reset_async: valid=%b pc=%h ld_size=%0d side=%h, want all zero", m_valid, m_pc, m_ld_size, m_side); end
        clear_inputs();
        #1 reset = 1;
    endtask

    task automatic test_reset_mid_stall();
        reset = 0;
        stall = 1;
        set_ex(MEM_LW, 32'h0000_0500, 32'h0000_0040, 32'h0, 0, 0);
        #1 reset = 1;
        step();
        tests++; if (m_valid !== 1'b0 || m_pc !== 32'h0) begin fails++; $display("FAIL reset_stall_hold: valid=%b pc=%h, want 0/0", m_valid, m_pc); end
        stall = 0;
        step();
        tests++; if (m_valid !== 1'b1 || m_pc !== 32'h0000_0500) begin fails++; $display("FAIL reset_stall_release: valid=%b pc=%h, want 1/00000500", m_valid, m_pc); end
        clear_inputs();
    endtask

    task automatic test_store_lanes();
        set_ex(MEM_SH, 32'h0000_0200, 32'h0000_1002, 32'h1234_ABCD, 0, 0);
        step();
        tests++; if (m_byteen !== 4'b1100 || m_wdata !== 32'hABCD_ABCD || m_exc !== 5'd0) begin fails++; $display("FAIL sh_hi: be=%b wdata=%h exc=%0d, want 1100/abcdabcd/0", m_byteen, m_wdata, m_exc); end
        set_ex(MEM_SB, 32'h0000_0204, 32'h0000_1001, 32'h1234_ABCD, 0, 0);
        step();
        tests++; if (m_byteen !== 4'b0010 || m_wdata !== 32'hCDCD_CDCD) begin fails++; $display("FAIL sb_1: be=%b wdata=%h, want 0010/cdcdcdcd", m_byteen, m_wdata); end
        set_ex(MEM_SW, 32'h0000_0208, 32'h0000_1000, 32'h1234_ABCD, 0, 0);
        step();
        tests++; if (m_byteen !== 4'b1111 || m_wdata !== 32'h1234_ABCD || m_ld_size !== 2'd0) begin fails++; $display("FAIL sw: be=%b wdata=%h size=%0d, want 1111/1234abcd/0", m_byteen, m_wdata, m_ld_size); end
        set_ex(MEM_SH, 32'h0000_020C, 32'h0000_1000, 32'h1234_ABCD, 0, 0);
        e_valid = 0;
        step();
        tests++; if (m_byteen !== 4'b0000 || m_valid !== 1'b0 || m_wdata !== 32'hABCD_ABCD) begin fails++; $display("FAIL sh_invalid: be=%b valid=%b wdata=%h, want 0000/0/abcdabcd", m_byteen, m_valid, m_wdata); end
        set_ex(MEM_SW, 32'h0000_0210, 32'h0000_1002, 32'h1111_2222, 0, 0);
        step();
        tests++; if (m_exc !== 5'd5 || m_byteen !== 4'b0000) begin fails++; $display("FAIL sw_misaligned: exc=%0d be=%b, want 5/0000", m_exc, m_byteen); end
        clear_inputs();
    endtask

    task automatic test_load();
        set_ex(MEM_LW, 32'h0000_0300, 32'h0000_1001, 32'h0, 0, 0);
        step();
        tests++; if (m_exc !== 5'd4 || m_ld_size !== 2'd0) begin fails++; $display("FAIL lw_misaligned: exc=%0d size=%0d, want 4/0", m_exc, m_ld_size); end
        set_ex(MEM_LW, 32'h0000_0304, 32'h0000_1001, 32'h0, 0, 5'd10);
        step();
        tests++; if (m_exc !== 5'd10 || m_ld_size !== 2'd0) begin fails++; $display("FAIL lw_prior_exc: exc=%0d size=%0d, want 10/0", m_exc, m_ld_size); end
        set_ex(MEM_LH, 32'h0000_0308, 32'h0000_1002, 32'h0, 0, 0);
        step();
        tests++; if (m_ld_size !== 2'd2 || m_ld_sext !== 1'b1 || m_exc !== 5'd0) begin fails++; $display("FAIL lh: size=%0d sext=%b exc=%0d, want 2/1/0", m_ld_size, m_ld_sext, m_exc); end
        set_ex(MEM_LBU, 32'h0000_030C, 32'h0000_1003, 32'h0, 0, 0);
        step();
        tests++; if (m_ld_size !== 2'd1 || m_ld_sext !== 1'b0 || m_exc !== 5'd0) begin fails++; $display("FAIL lbu: size=%0d sext=%b exc=%0d, want 1/0/0", m_ld_size, m_ld_sext, m_exc); end
        set_ex(MEM_LHU, 32'h0000_0310, 32'h0000_1001, 32'h0, 0, 0);
        step();
        tests++; if (m_exc !== 5'd4 || m_ld_size !== 2'd0) begin fails++; $display("FAIL lhu_misaligned: exc=%0d size=%0d, want 4/0", m_exc, m_ld_size); end
        clear_inputs();
    endtask

    task automatic test_overflow();
        set_ex(MEM_SB, 32'h0000_0400, 32'h0000_1003, 32'h0000_0077, 1, 0);
        step();
        tests++; if (m_exc !== 5'd5 || m_byteen !== 4'b0000) begin fails++; $display("FAIL sb_ov: exc=%0d be=%b, want 5/0000", m_exc, m_byteen); end
        set_ex(MEM_NONE, 32'h0000_0404, 32'h7FFF_FFFF, 32'h1, 1, 0);
        e_mtc0 = 1;
        step();
        tests++; if (m_exc !== 5'd12 || m_cp0_we !== 1'b0) begin fails++; $display("FAIL add_ov: exc=%0d cp0_we=%b, want 12/0", m_exc, m_cp0_we); end
        set_ex(MEM_NONE, 32'h0000_0408, 32'h0, 32'h1, 0, 0);
        e_mtc0 = 1;
        step();
        tests++; if (m_cp0_we !== 1'b1 || m_exc !== 5'd0) begin fails++; $display("FAIL mtc0: cp0_we=%b exc=%0d, want 1/0", m_cp0_we, m_exc); end
        set_ex(MEM_LB, 32'h0000_040C, 32'h0000_1001, 32'h0, 1, 0);
        step();
        tests++; if (m_exc !== 5'd4 || m_ld_sext !== 1'b0) begin fails++; $display("FAIL lb_ov: exc=%0d sext=%b, want 4/0", m_exc, m_ld_sext); end
        clear_inputs();
    endtask

    task automatic test_stall_int();
        set_ex(MEM_SW, 32'h0000_0200, 32'h0000_3000, 32'h1122_3344, 0, 0);
        step();
        tests++; if (m_byteen !== 4'b1111 || m_pc !== 32'h0000_0200) begin fails++; $display("FAIL stall_setup: be=%b pc=%h, want 1111/00000200", m_byteen, m_pc); end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_ex(MEM_LB, 32'h0000_0900 + 32'(i * 4), 32'h0000_0011, 32'h0000_00AA, 0, 0);
            e_valid = i[0];
            e_bd = 1;
            step();
            tests++; if (m_pc !== 32'h0000_0200 || m_byteen !== 4'b1111 || m_wdata !== 32'h1122_3344 || m_valid !== 1'b1 || m_ld_size !== 2'd0 || m_bd !== 1'b0) begin fails++; $display("FAIL stall_hold[%0d]: pc=%h be=%b wdata=%h valid=%b size=%0d bd=%b", i, m_pc, m_byteen, m_wdata, m_valid, m_ld_size, m_bd); end
        end
        int_req = 1;
        e_bd = 1;
        step();
        tests++; if (m_pc !== 32'h0000_4180 || m_valid !== 1'b0 || m_bd !== 1'b0) begin fails++; $display("FAIL int_redirect: pc=%h valid=%b bd=%b, want 00004180/0/0", m_pc, m_valid, m_bd); end
        tests++; if (m_instr !== 32'h0 || m_byteen !== 4'b0 || m_wdata !== 32'h0 || m_side !== 8'h0) begin fails++; $display("FAIL int_bubble: instr=%h be=%b wdata=%h side=%h, want zeros", m_instr, m_byteen, m_wdata, m_side); end
        clear_inputs();
    endtask

    task automatic test_flush();
        set_ex(MEM_SW, 32'h0000_3010, 32'h0000_1000, 32'h5555_6666, 0, 0);
        e_bd = 1; stall = 1; flush = 1;
        step();
        tests++; if (m_valid !== 1'b0 || m_pc !== 32'h0000_3010 || m_bd !== 1'b1) begin fails++; $display("FAIL flush_pc: valid=%b pc=%h bd=%b, want 0/00003010/1", m_valid, m_pc, m_bd); end
        tests++; if (m_byteen !== 4'b0 || m_instr !== 32'h0 || m_rd2 !== 32'h0 || m_ao !== 32'h0) begin fails++; $display("FAIL flush_bubble: be=%b instr=%h rd2=%h ao=%h, want zeros", m_byteen, m_instr, m_rd2, m_ao); end
        clear_inputs();
        set_ex(MEM_LH, 32'h0000_3014, 32'h0000_1000, 32'h0, 0, 0);
        flush = 1; int_req = 1; e_bd = 1;
        step();
        tests++; if (m_pc !== 32'h0000_4180 || m_bd !== 1'b0 || m_ld_size !== 2'd0) begin fails++; $display("FAIL int_over_flush: pc=%h bd=%b size=%0d, want 00004180/0/0", m_pc, m_bd, m_ld_size); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_reset_mid_stall();
        test_store_lanes();
        test_load();
        test_overflow();
        test_stall_int();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
